// File: rtl/doa_window_sequencer.sv
// Direction-of-arrival window sequencer: gates and clears the four correlator
// channels, waits for the angle LUT to settle, then range-checks and hands off one angle per window.
module doa_window_sequencer #(
  parameter int WINDOW_LEN = 200000,
  parameter int CNT_W      = 18,
  parameter int SETTLE     = 4,
  parameter int ANGLE_W    = 9,
  parameter int MAX_ANGLE  = 359
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               run,
  input  logic               clear_flags,
  input  logic [ANGLE_W-1:0] angle_in,
  output logic               cda_en,
  output logic               cda_clr,
  output logic               win_active,
  output logic [ANGLE_W-1:0] angle_out,
  output logic               angle_valid,
  input  logic               angle_ready,
  output logic               overrun,
  output logic               err_range,
  output logic [7:0]         win_count
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(WINDOW_LEN - 1);
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [ANGLE_W-1:0] ANGLE_MAX   = ANGLE_W'(MAX_ANGLE);

  typedef enum logic [2:0] {
    IDLE,
    ACQUIRE,
    SETTLE_ST,
    CAPTURE,
    CLEAR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               err_q, err_d;
  logic [7:0]         wincnt_q, wincnt_d;
  logic               capture;
  logic               legal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      settle_q  <= '0;
      angle_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
      wincnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      angle_q   <= angle_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
      wincnt_q  <= wincnt_d;
    end
  end

  // Abort on run=0 is checked before the window-end test so it wins in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    cda_en     = 1'b0;
    cda_clr    = 1'b0;
    win_active = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        cda_clr = 1'b1;
        cnt_d   = '0;
        if (run) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        win_active = 1'b1;
        cda_en     = en;
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (en) begin
          if (cnt_q == CNT_LAST) begin
            state_d  = SETTLE_ST;
            cnt_d    = '0;
            settle_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SETTLE_ST: begin
        win_active = 1'b1;
        if (settle_q == SETTLE_LAST) state_d = CAPTURE;
        else settle_d = settle_q + SET_W'(1);
      end
      CAPTURE: begin
        win_active = 1'b1;
        capture    = 1'b1;
        state_d    = CLEAR;
      end
      CLEAR: begin
        cda_clr = 1'b1;
        cnt_d   = '0;
        state_d = run ? ACQUIRE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Set events are applied after the clear so a coincident set leaves the flag high.
  always_comb begin
    legal     = (angle_in <= ANGLE_MAX);
    angle_d   = angle_q;
    valid_d   = valid_q & ~angle_ready;
    overrun_d = overrun_q & ~clear_flags;
    err_d     = err_q & ~clear_flags;
    wincnt_d  = wincnt_q;
    if (capture) begin
      wincnt_d = wincnt_q + 8'd1;
      if (legal) begin
        angle_d = angle_in;
        valid_d = 1'b1;
        if (valid_q && !angle_ready) overrun_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign angle_out   = angle_q;
  assign angle_valid = valid_q;
  assign overrun     = overrun_q;
  assign err_range   = err_q;
  assign win_count   = wincnt_q;

endmodule
